uart_receiver: RTL and testbench

Serial-to-parallel UART receiver sitting between the `FPGA_SERIAL_RX` pin and the MIPS150 CPU's memory-mapped UART data/status registers. It samples 8N1 frames at mid-bit on `cpu_clk_g` and presents each byte through a valid/ready handshake. It also flags framing errors and overruns so the CPU status register can report them.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_receiver_if.sv | 10 +
 rtl/sync_2ff.sv | 21 ++
 rtl/uart_receiver.sv | 77 +++++++
 tb/tb_uart_receiver.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and baud timing helpers
package uart_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  function automatic int clocks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction
  function automatic int sample_time(input int clock_freq, input int baud_rate);
    return clocks_per_bit(clock_freq, baud_rate) / 2;
  endfunction
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: received-byte handshake and line status flags
interface uart_receiver_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;
  modport master (output data_out, data_out_valid, framing_error, overrun, input data_out_ready);
  modport slave (input data_out, data_out_valid, framing_error, overrun, output data_out_ready);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous pins entering clk
module sync_2ff #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      s1_q <= d;
      q    <= s1_q;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 mid-bit sampling receiver with valid/ready output,
// framing-error and overrun pulses
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  uart_receiver_if.master bus
);
  localparam int CPB = clocks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int ST  = sample_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB);
  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          valid_q, valid_d, fe_q, fe_d, ov_q, ov_d;
  logic          bit_tick, half_tick, shift_en, stop_done, commit, take;
  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(serial_in), .q(rx_s));
  assign bit_tick  = cnt_q == CW'(CPB - 1);
  assign half_tick = cnt_q == CW'(ST - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rx_s ? IDLE : START;
      START:   state_d = half_tick ? (rx_s ? IDLE : DATA) : START;
      DATA:    state_d = (bit_tick && idx_q == 3'd7) ? STOP : DATA;
      default: state_d = bit_tick ? IDLE : STOP;
    endcase
  end
  // Stop sample returns to IDLE mid-stop-bit so a back-to-back start edge is caught.
  always_comb begin
    shift_en  = state_q == DATA && bit_tick;
    stop_done = state_q == STOP && bit_tick;
    commit    = stop_done && rx_s;
    take      = valid_q && bus.data_out_ready;
    cnt_d     = (state_q == IDLE || (state_q == START && half_tick) || shift_en || stop_done) ? '0 : cnt_q + 1'b1;
    idx_d     = shift_en ? idx_q + 3'd1 : idx_q;
    shift_d   = shift_en ? {rx_s, shift_q[7:1]} : shift_q;
    data_d    = (commit && (!valid_q || take)) ? shift_q : data_q;
    valid_d   = (commit && (!valid_q || take)) ? 1'b1 : take ? 1'b0 : valid_q;
    fe_d      = stop_done && !rx_s;
    ov_d      = commit && valid_q && !take;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end
  assign bus.data_out       = data_q;
  assign bus.data_out_valid = valid_q;
  assign bus.framing_error  = fe_q;
  assign bus.overrun        = ov_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames checked against
// spec-level timing and a byte scoreboard
module tb_uart_receiver;
  localparam int CF  = 4_608_000;
  localparam int BR  = 115_200;
  localparam int CPB = CF / BR;
  localparam int ST  = CPB / 2;
  localparam int LAT = 2 + ST + 9 * CPB + 1;
  logic clk = 1'b0, rst = 1'b1, serial_in = 1'b1;
  uart_receiver_if bus();
  uart_receiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (.clk(clk), .rst(rst), .serial_in(serial_in), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, long_cnt = 0, rise_cyc = 0;
  logic fe_p = 1'b0, ov_p = 1'b0, v_p = 1'b0;
  byte unsigned got[$], exp_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.framing_error) fe_cnt++;
    if (bus.overrun) ov_cnt++;
    if ((bus.framing_error && fe_p) || (bus.overrun && ov_p)) long_cnt++;
    if (bus.data_out_valid && !v_p) rise_cyc = cyc;
    fe_p = bus.framing_error;
    ov_p = bus.overrun;
    v_p  = bus.data_out_valid;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop_bit = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    serial_in = 1'b1;
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.data_out_valid !== 1'b1 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.data_out_valid, 1);
  endtask
  task automatic consume();
    bus.data_out_ready = 1'b1;
    @(negedge clk);
    bus.data_out_ready = 1'b0;
  endtask
  task automatic consumer(input int n);
    int b = 0;
    while (got.size() < n && b < n * 12 * CPB + 4 * LAT) begin
      @(negedge clk);
      b++;
      if (bus.data_out_valid && !bus.data_out_ready) begin
        got.push_back(bus.data_out);
        bus.data_out_ready = 1'b1;
      end else bus.data_out_ready = 1'b0;
    end
    if (bus.data_out_ready) @(negedge clk);
    bus.data_out_ready = 1'b0;
    chk("consumer_count", got.size(), n);
  endtask
  initial begin
    int t0, t2, f0, o0;
    logic [7:0] rb;
    bus.data_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_valid", bus.data_out_valid, 0);
    chk("rst_fe", bus.framing_error, 0);
    chk("rst_ov", bus.overrun, 0);
    rst = 1'b0;
    idle(2 * CPB);
    t0 = cyc;
    send_frame(8'hA5);
    wait_valid("a5_valid");
    chk("a5_latency", (rise_cyc - t0 >= LAT - 1 && rise_cyc - t0 <= LAT + 1) ? LAT : rise_cyc - t0, LAT);
    chk("a5_data", bus.data_out, 8'hA5);
    idle(3 * CPB);
    chk("a5_hold", bus.data_out_valid, 1);
    consume();
    chk("a5_drop", bus.data_out_valid, 0);
    f0 = fe_cnt;
    serial_in = 1'b0;
    idle(ST / 2);
    serial_in = 1'b1;
    idle(3 * CPB);
    chk("glitch_valid", bus.data_out_valid, 0);
    chk("glitch_fe", fe_cnt - f0, 0);
    send_frame(8'h3C);
    wait_valid("3c_valid");
    chk("3c_data", bus.data_out, 8'h3C);
    consume();
    f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    idle(3 * CPB);
    chk("fe_pulses", fe_cnt - f0, 1);
    chk("fe_valid", bus.data_out_valid, 0);
    send_frame(8'hFF);
    wait_valid("ff_valid");
    chk("ff_data", bus.data_out, 8'hFF);
    consume();
    o0 = ov_cnt;
    send_frame(8'h11);
    send_frame(8'h22);
    idle(CPB);
    chk("ov_data", bus.data_out, 8'h11);
    chk("ov_pulses", ov_cnt - o0, 1);
    chk("ov_valid", bus.data_out_valid, 1);
    consume();
    o0 = ov_cnt;
    send_frame(8'h11);
    t2 = cyc;
    fork
      send_frame(8'h22);
      begin
        while (cyc < t2 + LAT - 1) @(negedge clk);
        bus.data_out_ready = 1'b1;
        @(negedge clk);
        bus.data_out_ready = 1'b0;
      end
    join
    idle(CPB);
    chk("nov_data", bus.data_out, 8'h22);
    chk("nov_valid", bus.data_out_valid, 1);
    chk("nov_pulses", ov_cnt - o0, 0);
    consume();
    f0 = fe_cnt;
    o0 = ov_cnt;
    got.delete();
    fork
      for (int i = 0; i < 16; i++) send_frame(8'(i));
      consumer(16);
    join
    for (int i = 0; i < 16; i++) chk($sformatf("b2b_%0d", i), i < got.size() ? 32'(got[i]) : 'x, i);
    chk("b2b_fe", fe_cnt - f0, 0);
    chk("b2b_ov", ov_cnt - o0, 0);
    got.delete();
    exp_q.delete();
    fork
      for (int i = 0; i < 8; i++) begin
        rb = 8'($urandom_range(0, 255));
        exp_q.push_back(rb);
        send_frame(rb);
        idle($urandom_range(0, CPB));
      end
      consumer(8);
    join
    for (int i = 0; i < 8; i++) chk($sformatf("rnd_%0d", i), i < got.size() ? 32'(got[i]) : 'x, 32'(exp_q[i]));
    send_frame(8'h5A);
    wait_valid("pre_rst_valid");
    fork
      send_frame(8'hC3);
      begin
        idle(5 * CPB + CPB / 2);
        rst = 1'b1;
        #1;
        chk("mrst_data", bus.data_out, 8'h00);
        chk("mrst_valid", bus.data_out_valid, 0);
        chk("mrst_fe", bus.framing_error, 0);
        chk("mrst_ov", bus.overrun, 0);
      end
    join
    idle(2);
    rst = 1'b0;
    idle(3 * CPB);
    chk("mrst_no_byte", bus.data_out_valid, 0);
    send_frame(8'h7E);
    wait_valid("7e_valid");
    chk("7e_data", bus.data_out, 8'h7E);
    consume();
    idle(CPB);
    chk("pulse_width", long_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
